// File: rtl/fp_pkg.sv
// fp_pkg: shared class enum, flag indices and encoding helpers for the fp add/sub pipeline
package fp_pkg;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;
  localparam int FLAG_INV = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic logic [63:0] inf(input logic s, input int exp_w, input int man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r[exp_w+man_w] = s;
    return r;
  endfunction
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    return inf(1'b0, exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter; count is WIDTH when the input is all zero
module fp_lzc #(
  parameter int WIDTH = 14,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] x,
  output logic [CW-1:0]    count,
  output logic             zero
);
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (x[i]) count = CW'(WIDTH - 1 - i);
  end
  assign zero = ~|x;
endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 4-stage IEEE-754-style add/sub, RNE rounding, subnormal flush, valid/ready stall.
// Defining FPADD_FLAGS_EN adds flags[3:0] = {invalid, overflow, underflow, inexact}.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c
`ifdef FPADD_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);
  localparam int D = MAN_W + 4;
  localparam int LW = $clog2(D + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  fp_class_e ca, cb;
  logic sa, sb, a_big, spc;
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic [W-2:0] mag_a, mag_b;
  logic [D-1:0] sig_a, sig_b, sig_l, sig_s, sig_al;
  logic [W-1:0] spv;
  always_comb begin
    sa = a[W-1];
    sb = b[W-1] ^ op;
    ca = a[W-2:MAN_W] == '0 ? ZERO : a[W-2:MAN_W] != EMAX ? NORM : a[MAN_W-1:0] == '0 ? INF : NAN;
    cb = b[W-2:MAN_W] == '0 ? ZERO : b[W-2:MAN_W] != EMAX ? NORM : b[MAN_W-1:0] == '0 ? INF : NAN;
    ea = ca == ZERO ? '0 : a[W-2:MAN_W];
    eb = cb == ZERO ? '0 : b[W-2:MAN_W];
    mag_a = ca == ZERO ? '0 : a[W-2:0];
    mag_b = cb == ZERO ? '0 : b[W-2:0];
    sig_a = ca == ZERO ? '0 : {1'b1, a[MAN_W-1:0], 3'b000};
    sig_b = cb == ZERO ? '0 : {1'b1, b[MAN_W-1:0], 3'b000};
    a_big = mag_a >= mag_b;
    el = a_big ? ea : eb;
    es = a_big ? eb : ea;
    sig_l = a_big ? sig_a : sig_b;
    sig_s = a_big ? sig_b : sig_a;
    d = el - es;
    // bits shifted past the datapath fold into the sticky bit
    sig_al = 32'(d) >= MAN_W + 3 ? D'(|sig_s) : (sig_s >> d) | D'(|(sig_s << (D - 32'(d))));
    spc = ca == NAN || cb == NAN || ca == INF || cb == INF || (ca == ZERO && cb == ZERO);
    spv = ca == NAN || cb == NAN || (ca == INF && cb == INF && sa != sb) ? W'(qnan(EXP_W, MAN_W))
        : ca == INF ? W'(inf(sa, EXP_W, MAN_W)) : cb == INF ? W'(inf(sb, EXP_W, MAN_W))
        : {sa & sb, {(W-1){1'b0}}};
  end
  logic v1, v2, v3, spc1, spc2, spc3, s1, s2, s3, sub1;
  logic [W-1:0] spv1, spv2, spv3;
  logic [EXP_W-1:0] e1, e2;
  logic [EXP_W:0] e3;
  logic [D-1:0] l1, m1, sig3;
  logic [D:0] sum2;
  logic [LW-1:0] lz;
  logic lz_zero, unf, spc_n;
  logic [D-1:0] nsig;
  logic [EXP_W:0] nexp;
  logic [W-1:0] spv_n;
  fp_lzc #(.WIDTH(D)) u_lzc (.x(sum2[D-1:0]), .count(lz), .zero(lz_zero));
  always_comb begin
    unf = !sum2[D] && !lz_zero && 32'(lz) >= 32'(e2);
    nsig = sum2[D] ? {sum2[D:2], sum2[1] | sum2[0]} : sum2[D-1:0] << lz;
    nexp = sum2[D] ? {1'b0, e2} + (EXP_W+1)'(1) : {1'b0, e2} - (EXP_W+1)'(lz);
    // exact cancellation gives +0, underflow gives a signed zero
    spc_n = spc2 || (!sum2[D] && lz_zero) || unf;
    spv_n = spc2 ? spv2 : {unf & s2, {(W-1){1'b0}}};
  end
  logic inc, ovf;
  logic [MAN_W+1:0] rnd;
  logic [EXP_W:0] rexp;
  logic [W-1:0] res;
  always_comb begin
    inc = sig3[2] & (sig3[1] | sig3[0] | sig3[3]);
    rnd = {1'b0, sig3[D-1:3]} + (MAN_W+2)'(inc);
    rexp = e3 + (EXP_W+1)'(rnd[MAN_W+1]);
    ovf = rexp >= {1'b0, EMAX};
    res = spc3 ? spv3 : ovf ? {s3, EMAX, {MAN_W{1'b0}}}
        : {s3, rexp[EXP_W-1:0], rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0]};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_valid <= 1'b0;
      c <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      out_valid <= v3;
      c <= res;
    end
  always_ff @(posedge clk)
    if (adv) begin
      spc1 <= spc;
      spv1 <= spv;
      s1 <= a_big ? sa : sb;
      sub1 <= sa ^ sb;
      e1 <= el;
      l1 <= sig_l;
      m1 <= sig_al;
      spc2 <= spc1;
      spv2 <= spv1;
      s2 <= s1;
      e2 <= e1;
      sum2 <= sub1 ? {1'b0, l1} - {1'b0, m1} : {1'b0, l1} + {1'b0, m1};
      spc3 <= spc_n;
      spv3 <= spv_n;
      s3 <= s2;
      e3 <= nexp;
      sig3 <= nsig;
    end
`ifdef FPADD_FLAGS_EN
  logic inv1, inv2, inv3, unf3;
  always_ff @(posedge clk)
    if (adv) begin
      inv1 <= (ca == INF && cb == INF && sa != sb) || (ca == NAN && !a[MAN_W-1]) || (cb == NAN && !b[MAN_W-1]);
      inv2 <= inv1;
      inv3 <= inv2;
      unf3 <= !spc2 && unf;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) flags <= '0;
    else if (adv) begin
      flags[FLAG_INV] <= spc3 & inv3;
      flags[FLAG_OVF] <= !spc3 & ovf;
      flags[FLAG_UNF] <= spc3 & unf3;
      flags[FLAG_INX] <= spc3 ? unf3 : (|sig3[2:0] | ovf);
    end
`endif
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed vectors for binary16 and binary32 instances plus stall/reset sequences
module tb_fp_addsub_pipe;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic iv16, ir16, op16, ov16, or16;
  logic [15:0] a16, b16, c16;
  logic iv32, ir32, op32, ov32, or32;
  logic [31:0] a32, b32, c32;
`ifdef FPADD_FLAGS_EN
  logic [3:0] fl16, fl32;
`endif
  fp_addsub_pipe u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .op(op16),
    .out_valid(ov16), .out_ready(or16), .c(c16)
`ifdef FPADD_FLAGS_EN
    , .flags(fl16)
`endif
  );
  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .op(op32),
    .out_valid(ov32), .out_ready(or32), .c(c32)
`ifdef FPADD_FLAGS_EN
    , .flags(fl32)
`endif
  );
  typedef struct packed {
    logic        f32;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  localparam int NV = 26;
  vec_t vecs [NV];
  int total = 0, passed = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    if (v.f32) begin
      a32 = v.a; b32 = v.b; op32 = v.op; iv32 = 1'b1;
    end else begin
      a16 = v.a[15:0]; b16 = v.b[15:0]; op16 = v.op; iv16 = 1'b1;
    end
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    iv32 = 1'b0;
    n = 1;
    while (!(v.f32 ? ov32 : ov16) && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("latency%0d", idx), n, 4);
    check($sformatf("value%0d", idx), v.f32 ? c32 : {16'h0, c16}, v.exp);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] bs [8];
    logic [15:0] es [8];
    logic [15:0] hold;
    logic holding, acc;
    int sent, recv, extra;
    vecs[0]  = '{1'b0, 1'b0, 32'h3C00, 32'h3C00, 32'h4000};
    vecs[1]  = '{1'b0, 1'b1, 32'h4000, 32'h3C00, 32'h3C00};
    vecs[2]  = '{1'b0, 1'b1, 32'h3C00, 32'h3C00, 32'h0000};
    vecs[3]  = '{1'b0, 1'b0, 32'h8000, 32'h8000, 32'h8000};
    vecs[4]  = '{1'b0, 1'b0, 32'h7C00, 32'hFC00, 32'h7E00};
    vecs[5]  = '{1'b0, 1'b0, 32'h7E01, 32'h3C00, 32'h7E00};
    vecs[6]  = '{1'b0, 1'b0, 32'h7C00, 32'h3C00, 32'h7C00};
    vecs[7]  = '{1'b0, 1'b0, 32'h3C00, 32'h1000, 32'h3C00};
    vecs[8]  = '{1'b0, 1'b0, 32'h3C01, 32'h1000, 32'h3C02};
    vecs[9]  = '{1'b0, 1'b0, 32'h7BFF, 32'h7BFF, 32'h7C00};
    vecs[10] = '{1'b0, 1'b0, 32'h3C00, 32'hC000, 32'hBC00};
    vecs[11] = '{1'b0, 1'b1, 32'h0400, 32'h0401, 32'h8000};
    vecs[12] = '{1'b0, 1'b0, 32'h3C00, 32'h0001, 32'h3C00};
    vecs[13] = '{1'b0, 1'b0, 32'h3E00, 32'h3E00, 32'h4200};
    vecs[14] = '{1'b0, 1'b1, 32'h7C00, 32'h7C00, 32'h7E00};
    vecs[15] = '{1'b0, 1'b0, 32'h7C00, 32'h7C00, 32'h7C00};
    vecs[16] = '{1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000};
    vecs[17] = '{1'b1, 1'b1, 32'h40000000, 32'h3F800000, 32'h3F800000};
    vecs[18] = '{1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000};
    vecs[19] = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h80000000};
    vecs[20] = '{1'b1, 1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000};
    vecs[21] = '{1'b1, 1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000};
    vecs[22] = '{1'b1, 1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000};
    vecs[23] = '{1'b1, 1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000};
    vecs[24] = '{1'b1, 1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002};
    vecs[25] = '{1'b1, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    bs = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
    es = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};
    iv16 = 1'b0; op16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0;
    iv32 = 1'b0; op32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0;
    #12;
    check("reset_ov16", ov16, 0);
    check("reset_c16", c16, 0);
    check("reset_ov32", ov32, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_reset", ir16, 1);
    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);
    sent = 0; recv = 0; holding = 1'b0; hold = '0;
    for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
      @(negedge clk);
      or16 = !(cyc >= 4 && cyc < 9);
      iv16 = sent < 8;
      a16 = 16'h3C00;
      b16 = sent < 8 ? bs[sent] : 16'h0;
      op16 = 1'b0;
      #1;
      if (ov16 && !or16) begin
        check("stall_in_ready", ir16, 0);
        if (holding) check("stall_c_hold", c16, hold);
        hold = c16;
        holding = 1'b1;
      end
      if (ov16 && or16) begin
        check($sformatf("stream%0d", recv), c16, recv < 8 ? es[recv] : 16'hxxxx);
        recv++;
      end
      acc = iv16 && ir16;
      @(posedge clk);
      if (acc) sent++;
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    check("stream_count", recv, 8);
    check("stall_seen", holding, 1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov16) extra++;
    end
    check("stream_no_dup", extra, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv16 = 1'b1; a16 = 16'h3C00; b16 = bs[i]; op16 = 1'b0;
    end
    @(negedge clk);
    iv16 = 1'b0;
    check("pre_reset_ov", ov16, 1);
    rst = 1'b0;
    #1;
    check("midreset_ov", ov16, 0);
    check("midreset_c", c16, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (ov16) extra++;
    end
    check("flushed_ops", extra, 0);
    check("ready_after_midreset", ir16, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Parametrised IEEE-754-style floating-point add/subtract unit with a fixed 4-stage pipeline and a valid/ready handshake on both sides; the whole pipeline stalls on output backpressure.
- Default widths give binary16, so it replaces the existing fixed half-precision adder in the datapath.
- Adds an op select, guard/round/sticky rounding (round-to-nearest-even), zero/Inf/NaN handling, overflow saturation to Inf and subnormal flush-to-zero.

Parameters:
- EXP_W, 5: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10: stored fraction width; hidden bit is implicit.
- W, derived = 1+EXP_W+MAN_W; not user-overridable (localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  operands present.
- in_ready  out  1  unit accepts operands this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  1  0 = A+B, 1 = A−B (B sign inverted at stage 1).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- c  out  W  result.

Behaviour:
- Reset (rst=0, async): all stage valid bits cleared; out_valid=0; c=0. in_ready is 1 once rst=1.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - Every stage register loads only when adv=1.
  - Bubbles propagate; a stage's valid bit shifts with its data.
- Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
  - Latency is exactly 4 cycles from accept to out_valid with no stall.
  - Throughput is 1 per cycle.
  - While out_valid && !out_ready, c and out_valid hold stable.
- Stage 1, unpack/classify/align:
  - Classify zero, subnormal (flushed to zero), normal, Inf, NaN.
  - Pick the larger-magnitude operand by {exp, frac}.
  - Right-shift the smaller significand by the exponent difference into a MAN_W+4-bit datapath (hidden, frac, G, R, S).
  - Bits shifted below S OR into S.
  - If the difference ≥ MAN_W+3, the smaller operand collapses to S = (smaller ≠ 0).
- Stage 2, add/sub:
  - Effective subtract = sign_a XOR sign_b XOR op.
  - Magnitude result is always large − small, so it is non-negative; result sign = sign of the larger operand.
  - Sum width MAN_W+5, including the carry bit.
- Stage 3, normalise:
  - Carry set: shift right 1 (keep sticky), exp+1.
  - Otherwise: left-shift by the leading-zero count, exp−lzc.
  - If exp−lzc ≤ 0: flush to signed zero (underflow).
- Stage 4, round/pack:
  - Round-to-nearest-even: increment when G && (R || S || lsb).
  - Rounding carry-out renormalises, exp+1.
  - exp ≥ 2^EXP_W−1 after rounding: result = ±Inf, overflow.
- Specials, resolved in stage 1 and carried as a bypass result:
  - Any NaN, or Inf − Inf (effective subtract): canonical quiet NaN {0, all-ones exp, 1 followed by zeros}.
  - Exactly one Inf: that Inf, with its effective sign.
  - Both operands zero: +0, except (−0)+(−0) = −0.
  - Exact cancellation of non-zero operands: +0.
- Mid-operation reset: in-flight results are discarded and no out_valid is produced for them.

Optional Feature:
FPADD_FLAGS_EN
- When defined: adds output flags[3:0] = {invalid, overflow, underflow, inexact}.
  - Valid with c, held under stall, reset to 0.
  - inexact = G|R|S before rounding, or overflow, or flushed underflow.
- When undefined: no flags port and no flag logic; c is bit-identical in both builds.

Decomposition:
- Package fp_pkg:
  - fp class enum (ZERO, NORM, INF, NAN).
  - Functions: bias(EXP_W), qnan(EXP_W, MAN_W), inf(sign, EXP_W, MAN_W).
  - Flag bit index constants.
- Sub-module fp_lzc: parametrised leading-zero counter (WIDTH in, count out, all-zero flag), used in stage 3.

Test Plan:
1. Basic arithmetic, no stall, out_ready=1:
   - 0x3C00+0x3C00, op=0 → 0x4000 after exactly 4 cycles.
   - 0x4000 with op=1 against 0x3C00 → 0x3C00.
2. Exact cancellation: 0x3C00 − 0x3C00 → 0x0000 (+0); −0+−0 (0x8000, 0x8000) → 0x8000.
3. Specials:
   - 0x7C00 + 0xFC00 → 0x7E00 (invalid).
   - 0x7E01 + 0x3C00 → 0x7E00.
   - 0x7C00 + 0x3C00 → 0x7C00.
4. Rounding and overflow:
   - 0x3C00 + 0x1000 (tie) → 0x3C00, inexact.
   - 0x3C01 + 0x1000 → 0x3C02.
   - 0x7BFF + 0x7BFF → 0x7C00, overflow.
5. Backpressure:
   - Stream 8 back-to-back ops; hold out_ready=0 for 5 cycles mid-stream.
   - Required: no loss or duplication, in-order results, c stable while stalled, in_ready=0 during the stall.
6. Reset and parameter sweep:
   - Assert rst=0 with 3 ops in flight → out_valid=0 immediately, and none of the 3 ops appears after release.
   - Repeat tests 1–4 with EXP_W=8, MAN_W=23 against a float reference model.
